hilo_muldiv: RTL

Parametrised HI/LO unit for the EX stage. Holds the HI/LO pair and adds a multi-cycle multiplier/accumulator and an iterative divider that write HI/LO directly. MTHI/MTLO write each half independently. Drives busy/done for pipeline stall control, and accepts a flush cancel from the pipeline control logic.

---
 rtl/hilo_muldiv.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO register pair for the EX stage with a multi-cycle multiply/accumulate
// unit and an iterative restoring divider; direct MTHI/MTLO writes win over results.
module hilo_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DIV0} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] hi, lo, a_q, b_q, quo, rem, dvs;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic             launch, fire, flag;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Product is formed at 2*WIDTH so signed and unsigned share one multiplier.
  logic               sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mac;
  assign sgn   = ~op_q[0];
  assign ext_a = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  always_comb begin
    case (op_q[2:1])
      2'b10:   mac = {hi, lo} + prod;
      2'b11:   mac = {hi, lo} - prod;
      default: mac = prod;
    endcase
  end

  // Divider works on magnitudes; signs are reapplied on the final edge.
  logic [WIDTH:0] shifted, trial;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  logic sgn_in, a_neg, b_neg;
  assign sgn_in = ~op[0];
  assign a_neg  = sgn_in & op_a[WIDTH-1];
  assign b_neg  = sgn_in & op_b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    fire    = 1'b0;
    flag    = 1'b0;
    res_hi  = hi;
    res_lo  = lo;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          launch = 1'b1;
          if (op[2] || !op[1])  state_n = MUL;
          else if (op_b == '0)  state_n = DIV0;
          else                  state_n = DIV;
        end
      end
      MUL: begin
        if (cancel) state_n = IDLE;
        else if (cnt == CW'(MUL_CYCLES - 1)) begin
          fire    = 1'b1;
          res_hi  = mac[2*WIDTH-1:WIDTH];
          res_lo  = mac[WIDTH-1:0];
          state_n = IDLE;
        end
      end
      DIV: begin
        if (cancel) state_n = IDLE;
        else if (cnt == CW'(WIDTH)) begin
          fire    = 1'b1;
          res_hi  = neg_r ? -rem : rem;
          res_lo  = neg_q ? -quo : quo;
          state_n = IDLE;
        end
      end
      DIV0: begin
        if (cancel) state_n = IDLE;
        else begin
          fire    = 1'b1;
          flag    = 1'b1;
          res_hi  = a_q;
          res_lo  = '1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      div0  <= 1'b0;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= fire;
      div0 <= fire & flag;
      hi   <= we_hi ? wdata : res_hi;
      lo   <= we_lo ? wdata : res_lo;
      if (launch) begin
        op_q  <= op;
        a_q   <= op_a;
        b_q   <= op_b;
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        quo   <= a_neg ? -op_a : op_a;
        dvs   <= b_neg ? -op_b : op_b;
        rem   <= '0;
      end else if (state == DIV && cnt != CW'(WIDTH)) begin
        cnt <= cnt + CW'(1);
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end else if (state == MUL) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;
  assign busy = (state != IDLE);
endmodule
